serial_restador: RTL

SERIAL_RESTADOR -- requirements
Module: serial_restador

---
 rtl/serial_restador.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_restador.sv
// Bit-serial subtractor: computes a - b - b_in one bit per cycle, LSB first.
// The visible result/b_out only change when the last bit is produced, so
// observers never see a partially built difference.
module serial_restador #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         b_out,
  output logic         zero
);

  // Counter only needs to reach N-1; keep at least one bit for N=1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_sr, b_sr, res_sr, res_nxt;
  logic           bor, bor_nxt, d;
  logic [CW-1:0]  cnt;
  logic           last;

  assign last = (cnt == CW'(N-1));
  assign zero = ~|result;

  // One-bit full subtractor on the current LSBs plus the next working result.
  always_comb begin
    d       = a_sr[0] ^ b_sr[0] ^ bor;
    bor_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
    res_nxt = res_sr >> 1;
    res_nxt[N-1] = d;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial datapath, and the visible result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      result <= '0;
      b_out  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr   <= a;
      b_sr   <= b;
      bor    <= b_in;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      bor    <= bor_nxt;
      res_sr <= res_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        result <= res_nxt;
        b_out  <= bor_nxt;
      end
    end
  end

endmodule
